msb_pos_serializer: RTL and testbench

MSB_POS_SERIALIZER -- requirements
Module: msb_pos_serializer

---
 rtl/msb_pos_serializer.sv | 84 ++++++++
 tb/tb_msb_pos_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/msb_pos_serializer.sv
// Serialises the set-bit positions of an 8-bit word, highest first, emitting at
// most MAX_POS beats per word; lower set bits beyond that limit are dropped.
module msb_pos_serializer #(
  parameter int MAX_POS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_pos,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0] state;
  logic [7:0] residual;
  logic [2:0] rank;

  logic [2:0] top_pos;
  logic       one_left;
  logic       at_limit;
  logic       beat_last;

  // Lowest-to-highest scan so the final write wins with the highest set bit.
  always_comb begin
    top_pos = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (residual[i]) top_pos = 3'(i);
    end
  end

  assign one_left  = ((residual & (residual - 8'd1)) == 8'd0);
  assign at_limit  = (rank == 3'(MAX_POS - 1));
  assign beat_last = one_left || at_limit;

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == EMIT);
    out_valid = (state == EMIT);
    out_pos   = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (state == EMIT) begin
      out_pos  = top_pos;
      out_idx  = rank;
      out_last = beat_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      residual <= '0;
      rank     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero word is consumed without leaving IDLE.
          if (in_valid && in_data != 8'd0) begin
            residual <= in_data;
            rank     <= '0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            residual[top_pos] <= 1'b0;
            rank              <= rank + 3'd1;
            if (beat_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msb_pos_serializer.sv
// Bench for msb_pos_serializer: two instances (MAX_POS=3 and MAX_POS=1) share
// stimulus and are compared each cycle against a beat-list reference model.
module tb_msb_pos_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready  [2];
  logic [2:0] out_pos   [2];
  logic [2:0] out_idx   [2];
  logic       out_last  [2];
  logic       out_valid [2];
  logic       busy      [2];

  int checks = 0;
  int errors = 0;

  // Reference model: on acceptance the whole expected beat list is built up front.
  int mp [2] = '{3, 1};
  int bp [2][8];
  int bi [2][8];
  int bl [2][8];
  int nb [2] = '{0, 0};
  int hd [2] = '{0, 0};

  always #5 clk = ~clk;

  msb_pos_serializer #(.MAX_POS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_pos(out_pos[0]), .out_idx(out_idx[0]),
    .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .busy(busy[0])
  );

  msb_pos_serializer #(.MAX_POS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_pos(out_pos[1]), .out_idx(out_idx[1]),
    .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .busy(busy[1])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      bit pend;
      pend = (hd[m] < nb[m]);
      chk($sformatf("in_ready[%0d]", m),  int'(in_ready[m]),  int'(!pend));
      chk($sformatf("busy[%0d]", m),      int'(busy[m]),      int'(pend));
      chk($sformatf("out_valid[%0d]", m), int'(out_valid[m]), int'(pend));
      chk($sformatf("out_pos[%0d]", m),   int'(out_pos[m]),   pend ? bp[m][hd[m]] : 0);
      chk($sformatf("out_idx[%0d]", m),   int'(out_idx[m]),   pend ? bi[m][hd[m]] : 0);
      chk($sformatf("out_last[%0d]", m),  int'(out_last[m]),  pend ? bl[m][hd[m]] : 0);
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        nb[m] = 0;
        hd[m] = 0;
      end else if (hd[m] < nb[m]) begin
        if (out_ready) hd[m]++;
      end else if (in_valid && in_data != 8'd0) begin
        nb[m] = 0;
        hd[m] = 0;
        for (int p = 7; p >= 0; p--) begin
          if (in_data[p] && nb[m] < mp[m]) begin
            bp[m][nb[m]] = p;
            bi[m][nb[m]] = nb[m];
            nb[m]++;
          end
        end
        for (int k = 0; k < nb[m]; k++) bl[m][k] = (k == nb[m] - 1) ? 1 : 0;
      end
    end
  endtask

  // Check at the falling edge, advance the model, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    step();

    // Truncation to three beats, then idle.
    send(8'b1011_0110);
    repeat (4) step();

    // Single-bit word, then a dropped zero word.
    send(8'h01);
    repeat (2) step();
    send(8'h00);
    repeat (2) step();

    // Backpressure holds the first beat.
    out_ready = 1'b0;
    send(8'hC0);
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Reset mid-word: the remaining beats must never appear.
    send(8'hFF);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_resume_valid", int'(out_valid[0]), 0);
      step();
    end

    // MAX_POS=1 instance sees a single beat for 7F.
    send(8'h7F);
    repeat (4) step();

    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = 8'h00;
        1:       in_data = 8'(1 << $urandom_range(0, 7));
        default: in_data = 8'($urandom);
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
